// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// One bit per clock on x; a new word may be accepted in the stop cycle for gapless frames.
module parity_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              frame_active,
  output logic              sof
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              x_q, x_d;
  logic              fa_q, fa_d;
  logic              sof_q, sof_d;
  logic              accept;

  function automatic logic calc_parity(input logic [DATA_W-1:0] w);
    return (^w) ^ (PARITY_ODD != 0);
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept   = in_valid && in_ready;

  // Outputs are computed for the next state so x, sof and frame_active stay registered.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    x_d     = 1'b1;
    fa_d    = 1'b0;
    sof_d   = 1'b0;
    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d = START;
          sreg_d  = in_data;
          par_d   = calc_parity(in_data);
          cnt_d   = '0;
          x_d     = 1'b0;
          sof_d   = 1'b1;
          fa_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        x_d     = sreg_q[0];
        sreg_d  = sreg_q >> 1;
        cnt_d   = '0;
        fa_d    = 1'b1;
      end
      DATA: begin
        fa_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY;
          x_d     = par_q;
        end else begin
          x_d    = sreg_q[0];
          sreg_d = sreg_q >> 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
        x_d     = 1'b1;
        fa_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      x_q     <= 1'b1;
      fa_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      x_q     <= x_d;
      fa_q    <= fa_d;
      sof_q   <= sof_d;
    end
  end

  assign x            = x_q;
  assign frame_active = fa_q;
  assign sof          = sof_q;

endmodule
